// File: rtl/avg3_stream_frontend.sv
// avg3_stream_frontend
//   Upstream driver and result collector for a fixed-latency, non-stalling
//   3-input averaging pipeline. Input bytes are packed into triplets and
//   issued on a/b/c. Each triplet is tracked through the pipeline latency,
//   and its average is captured into a small result FIFO. Results are
//   presented as a valid/ready byte stream. A credit check on byte 2 of
//   every triplet guarantees that no result can arrive at a full FIFO.
//
//   Optional feature: define AVG3_FLUSH_EN to add flush/flush_drop.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush, flush_drop     (AVG3_FLUSH_EN only) discard partial triplet / pulse
//   s_valid/s_ready/s_data  input byte stream
//   a, b, c, issue        triplet to the averaging pipeline (registered)
//   avg_in                average returned by the pipeline, LAT cycles later
//   m_valid/m_ready/m_data  result byte stream
module avg3_stream_frontend #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
`ifdef AVG3_FLUSH_EN
  input  logic       flush,
  output logic       flush_drop,
`endif
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic       issue,
  input  logic [7:0] avg_in,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data
);

  localparam int unsigned PW = $clog2(DEPTH);          // FIFO pointer width
  localparam int unsigned CW = $clog2(DEPTH + 1);      // FIFO count width
  localparam int unsigned SW = $clog2(DEPTH + LAT + 2); // credit sum width

  logic [1:0]     r_cnt;
  logic [7:0]     r_byte0;
  logic [7:0]     r_byte1;
  logic [7:0]     r_a;
  logic [7:0]     r_b;
  logic [7:0]     r_c;
  logic           r_issue;
  logic [LAT-1:0] r_vld;
  logic [7:0]     r_mem [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;

  logic           w_acc;
  logic           w_flush;
  logic           w_wr;
  logic           w_rd;
  logic [SW-1:0]  w_inflight;
  logic           w_credit_ok;

`ifdef AVG3_FLUSH_EN
  logic r_flush_drop;
  assign w_flush    = flush;
  assign flush_drop = r_flush_drop;

  // One-cycle pulse only when a partial triplet is actually discarded.
  always_ff @(posedge clk) begin
    if (rst) r_flush_drop <= 1'b0;
    else     r_flush_drop <= flush && (r_cnt != 2'd0);
  end
`else
  assign w_flush = 1'b0;
`endif

  // Triplets issued but not yet captured: the issue slot plus the delay line.
  always_comb begin
    w_inflight = SW'(r_issue);
    for (int unsigned i = 0; i < LAT; i++) begin
      w_inflight = w_inflight + SW'(r_vld[i]);
    end
  end

  // A pop in the current cycle is deliberately not credited.
  assign w_credit_ok = (SW'(r_count) + w_inflight) < SW'(DEPTH);
  assign s_ready     = !rst && ((r_cnt != 2'd2) || w_credit_ok);
  assign w_acc       = s_valid && s_ready;

  // Byte collection and triplet issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= 2'd0;
      r_byte0 <= 8'd0;
      r_byte1 <= 8'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_c     <= 8'd0;
      r_issue <= 1'b0;
    end else begin
      r_issue <= 1'b0;
      if (w_flush) begin
        // Flush wins over a same-cycle accept: that byte is discarded too.
        r_cnt <= 2'd0;
      end else if (w_acc) begin
        case (r_cnt)
          2'd0: begin
            r_byte0 <= s_data;
            r_cnt   <= 2'd1;
          end
          2'd1: begin
            r_byte1 <= s_data;
            r_cnt   <= 2'd2;
          end
          default: begin
            r_a     <= r_byte0;
            r_b     <= r_byte1;
            r_c     <= s_data;
            r_issue <= 1'b1;
            r_cnt   <= 2'd0;
          end
        endcase
      end
    end
  end

  // Valid delay line mirroring the pipeline latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= r_issue;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
      end
    end
  end

  assign w_wr = r_vld[LAT-1];
  assign w_rd = m_valid && m_ready;

  // Result FIFO; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= avg_in;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign a       = r_a;
  assign b       = r_b;
  assign c       = r_c;
  assign issue   = r_issue;
  assign m_valid = (r_count != CW'(0));
  assign m_data  = r_mem[r_rptr];

endmodule

// File: tb/tb_avg3_stream_frontend.sv
// Testbench for avg3_stream_frontend: behavioural 3-stage averaging pipeline,
// byte-assembly scoreboard, FIFO occupancy model, scenario tasks.
module tb_avg3_stream_frontend;

  localparam int unsigned LAT   = 3;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'd0;
  logic [7:0] a, b, c;
  logic       issue;
  logic [7:0] avg_in;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
`ifdef AVG3_FLUSH_EN
  logic       flush = 1'b0;
  logic       flush_drop;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb [$];
  int         bcnt = 0;
  logic [7:0] bb0 = 8'd0;
  logic [7:0] bb1 = 8'd0;
  int         occ = 0;

  logic [7:0] p1 = 8'd0, p2 = 8'd0, p3 = 8'd0;
  logic       pv1 = 1'b0, pv2 = 1'b0, pv3 = 1'b0;

  always #5 clk = ~clk;

  avg3_stream_frontend #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef AVG3_FLUSH_EN
    .flush      (flush),
    .flush_drop (flush_drop),
`endif
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .a          (a),
    .b          (b),
    .c          (c),
    .issue      (issue),
    .avg_in     (avg_in),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
  );

  assign avg_in = p3;

  // Non-stalling averaging pipeline plus FIFO occupancy model.
  always @(posedge clk) begin
    p1 <= 8'((10'(a) + 10'(b) + 10'(c)) / 10'd3);
    p2 <= p1;
    p3 <= p2;
    if (rst) begin
      pv1 <= 1'b0; pv2 <= 1'b0; pv3 <= 1'b0;
      occ <= 0;
      sb.delete();
      bcnt = 0;
    end else begin
      pv1 <= issue; pv2 <= pv1; pv3 <= pv2;
      if (pv3) begin
        n_vec++;
        if (occ == DEPTH && !(m_valid && m_ready)) begin
          n_err++;
          $display("FAIL fifo_overflow: write into full fifo, occupancy %0d required < %0d", occ, DEPTH);
        end
      end
      occ <= occ + (pv3 ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end
  end

  // Scoreboard: record accepted bytes, compare popped results.
  always @(negedge clk) begin
    logic [7:0] exp_v;
    if (!rst) begin
      n_vec++;
      if (m_valid !== (occ != 0)) begin
        n_err++;
        $display("FAIL m_valid_occ: m_valid=%b required %b", m_valid, (occ != 0));
      end
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_result: m_data=%0d with no expected result", m_data);
        end else begin
          exp_v = sb.pop_front();
          n_vec++;
          if (m_data !== exp_v) begin
            n_err++;
            $display("FAIL result: m_data=%0d required %0d", m_data, exp_v);
          end
        end
      end
`ifdef AVG3_FLUSH_EN
      if (flush) bcnt = 0;
      else
`endif
      if (s_valid && s_ready) begin
        case (bcnt)
          0:       bb0 = s_data;
          1:       bb1 = s_data;
          default: sb.push_back(8'((10'(bb0) + 10'(bb1) + 10'(s_data)) / 10'd3));
        endcase
        bcnt = (bcnt == 2) ? 0 : bcnt + 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] v);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = v;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: byte %0d not accepted, s_ready=%b required 1", v, s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !m_valid && !issue && !pv1 && !pv2 && !pv3) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_vec++;
    if ({s_ready, issue, m_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_ctrl: s_ready,issue,m_valid=%b required 000", {s_ready, issue, m_valid});
    end
    n_vec++;
    if ({a, b, c, m_data} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_data: a,b,c,m_data=%h required 0", {a, b, c, m_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: s_ready=%b required 1", s_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_latency();
    m_ready = 1'b1;
    send_byte(8'd3);
    send_byte(8'd6);
    s_valid = 1'b1;
    s_data  = 8'd9;
    @(negedge clk);
    n_vec++;
    if (s_ready !== 1'b1) begin
      n_err++;
      $display("FAIL byte2_ready: s_ready=%b required 1", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_vec++;
        if (issue !== 1'b1 || {a, b, c} !== {8'd3, 8'd6, 8'd9}) begin
          n_err++;
          $display("FAIL issue_abc: issue=%b abc=%0d,%0d,%0d required 1 3,6,9", issue, a, b, c);
        end
      end
      if (k == 2) begin
        n_vec++;
        if (issue !== 1'b0 || {a, b, c} !== {8'd3, 8'd6, 8'd9}) begin
          n_err++;
          $display("FAIL issue_pulse: issue=%b abc=%0d,%0d,%0d required 0 3,6,9", issue, a, b, c);
        end
      end
      n_vec++;
      if (m_valid !== (k == 5)) begin
        n_err++;
        $display("FAIL latency_k%0d: m_valid=%b required %b", k, m_valid, (k == 5));
      end
    end
    @(posedge clk); #1;
    wait_drain();
  endtask

  task automatic test_width();
    logic [7:0] tv [9] = '{8'd255, 8'd255, 8'd255, 8'd1, 8'd1, 8'd0, 8'd2, 8'd2, 8'd2};
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(tv[i]);
    wait_drain();
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      for (int j = 0; j < 3; j++) send_byte(8'(t));
    end
    send_byte(8'd5);
    send_byte(8'd5);
    s_valid = 1'b1;
    s_data  = 8'd5;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_vec++;
      if (s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL credit_stall_%0d: s_ready=%b required 0", k, s_ready);
      end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send_byte(8'd5);
    for (int j = 0; j < 3; j++) send_byte(8'd6);
    wait_drain();
  endtask

  task automatic test_toggle();
    bit done = 1'b0;
    m_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 10; t++) begin
          for (int j = 0; j < 3; j++) send_byte(8'($urandom_range(0, 255)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 10));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if ({s_ready, issue, m_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL midrst_ctrl: s_ready,issue,m_valid=%b required 000", {s_ready, issue, m_valid});
    end
    n_vec++;
    if ({a, b, c, m_data} !== 32'd0) begin
      n_err++;
      $display("FAIL midrst_data: a,b,c,m_data=%h required 0", {a, b, c, m_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (m_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_stale_%0d: m_valid=%b required 0", k, m_valid);
      end
    end
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) send_byte(8'd9);
    wait_drain();
  endtask

`ifdef AVG3_FLUSH_EN
  task automatic test_flush();
    m_ready = 1'b1;
    send_byte(8'd7);
    send_byte(8'd8);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if (flush_drop !== 1'b1 || issue !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pulse: flush_drop=%b issue=%b required 1 0", flush_drop, issue);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (flush_drop !== 1'b0 || issue !== 1'b0) begin
      n_err++;
      $display("FAIL flush_one_cycle: flush_drop=%b issue=%b required 0 0", flush_drop, issue);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if (flush_drop !== 1'b0) begin
      n_err++;
      $display("FAIL flush_empty: flush_drop=%b required 0", flush_drop);
    end
    @(posedge clk); #1;
    send_byte(8'd4);
    send_byte(8'd5);
    send_byte(8'd6);
    wait_drain();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_latency();
    test_width();
    test_backpressure();
    test_toggle();
    test_reset_mid();
`ifdef AVG3_FLUSH_EN
    test_flush();
`endif
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d expected results never produced, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
